// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the stall controller and the surrounding pipeline.
// The master side is the controller, and the slave side is the pipeline/hazard/memory logic.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic             hazard_stall;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXWrite;
    logic             IDEXBubble;
    logic             EXMEMWrite;
    logic             MEMWBBubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        input  hazard_stall, branch_taken, dmem_req, dmem_ready,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble,
               EXMEMWrite, MEMWBBubble, mem_timeout, stall_count, flush_count
    );

    modport slave (
        output hazard_stall, branch_taken, dmem_req, dmem_ready,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble,
               EXMEMWrite, MEMWBBubble, mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Merges load-use, branch-flush and data-memory wait sources into pipeline
// register enables, with a memory-wait watchdog and wrapping stall/flush counters.
module pipeline_stall_controller #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipeline_stall_controller_if.master   bus
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic [TO_W-1:0]  wait_r, wait_next_s, cur_wait_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
    logic             mem_timeout_r;

    logic pc_write_s, ifid_write_s, ifid_flush_s, idex_write_s;
    logic idex_bubble_s, exmem_write_s, memwb_bubble_s;
    logic flush_inc_s, stall_inc_s, run_rules_s, freeze_s;

    // Next-state, wait-counter and combinational control outputs
    always_comb begin
        state_next_s   = state_r;
        wait_next_s    = wait_r;
        cur_wait_s     = wait_r + TO_W'(1);
        pc_write_s     = 1'b0;
        ifid_write_s   = 1'b0;
        ifid_flush_s   = 1'b0;
        idex_write_s   = 1'b0;
        idex_bubble_s  = 1'b0;
        exmem_write_s  = 1'b0;
        memwb_bubble_s = 1'b0;
        flush_inc_s    = 1'b0;
        run_rules_s    = 1'b0;
        freeze_s       = 1'b0;

        if (!rst_n) begin
            state_next_s = RUN;
            wait_next_s  = '0;
        end else begin
            case (state_r)
                RUN: begin
                    if (bus.dmem_req && !bus.dmem_ready) begin
                        freeze_s     = 1'b1;
                        state_next_s = MEM_WAIT;
                        wait_next_s  = TO_W'(1);
                    end else begin
                        run_rules_s  = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // A dropped request counts as completion
                    if (!bus.dmem_req || bus.dmem_ready) begin
                        run_rules_s  = 1'b1;
                        state_next_s = RUN;
                        wait_next_s  = '0;
                    end else begin
                        freeze_s    = 1'b1;
                        wait_next_s = cur_wait_s;
                        // cur_wait_s is the ordinal of this frozen cycle; the RUN entry cycle was the first
                        if (cur_wait_s == TO_W'(TIMEOUT)) begin
                            state_next_s = ERROR;
                        end else begin
                            state_next_s = MEM_WAIT;
                        end
                    end
                end
                ERROR: begin
                    state_next_s = ERROR;
                end
                default: begin
                    state_next_s = RUN;
                    wait_next_s  = '0;
                end
            endcase

            if (freeze_s) begin
                memwb_bubble_s = 1'b1;
            end else if (run_rules_s) begin
                pc_write_s    = 1'b1;
                ifid_write_s  = 1'b1;
                idex_write_s  = 1'b1;
                exmem_write_s = 1'b1;
                if (bus.branch_taken) begin
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    flush_inc_s   = 1'b1;
                end else if (bus.hazard_stall) begin
                    pc_write_s    = 1'b0;
                    ifid_write_s  = 1'b0;
                    idex_bubble_s = 1'b1;
                end else begin
                    idex_bubble_s = 1'b0;
                end
            end else begin
                memwb_bubble_s = 1'b0;
            end
        end
    end

    assign stall_inc_s = rst_n && !pc_write_s && (state_r != ERROR);

    // State, wait counter, sticky timeout flag and performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= RUN;
            wait_r        <= '0;
            mem_timeout_r <= 1'b0;
            stall_cnt_r   <= '0;
            flush_cnt_r   <= '0;
        end else begin
            state_r       <= state_next_s;
            wait_r        <= wait_next_s;
            mem_timeout_r <= mem_timeout_r || (state_next_s == ERROR);
            stall_cnt_r   <= stall_cnt_r + (stall_inc_s ? CNT_W'(1) : CNT_W'(0));
            flush_cnt_r   <= flush_cnt_r + (flush_inc_s ? CNT_W'(1) : CNT_W'(0));
        end
    end

    assign bus.PCWrite     = pc_write_s;
    assign bus.IFIDWrite   = ifid_write_s;
    assign bus.IFIDFlush   = ifid_flush_s;
    assign bus.IDEXWrite   = idex_write_s;
    assign bus.IDEXBubble  = idex_bubble_s;
    assign bus.EXMEMWrite  = exmem_write_s;
    assign bus.MEMWBBubble = memwb_bubble_s;
    assign bus.mem_timeout = mem_timeout_r;
    assign bus.stall_count = stall_cnt_r;
    assign bus.flush_count = flush_cnt_r;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with CNT_W=4 and TIMEOUT=4.
module tb_pipeline_stall_controller;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pipeline_stall_controller_if #(.CNT_W(4)) bus ();

    pipeline_stall_controller #(.CNT_W(4), .TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] C_OFF    = 7'b0000000;
    localparam logic [6:0] C_IDLE   = 7'b1101010;
    localparam logic [6:0] C_LOAD   = 7'b0001110;
    localparam logic [6:0] C_FLUSH  = 7'b1111110;
    localparam logic [6:0] C_FREEZE = 7'b0000001;

    function automatic logic [6:0] ctrl();
        return {bus.PCWrite, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXWrite,
                bus.IDEXBubble, bus.EXMEMWrite, bus.MEMWBBubble};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic hs, input logic bt, input logic req, input logic rdy);
        @(negedge clk);
        bus.hazard_stall = hs;
        bus.branch_taken = bt;
        bus.dmem_req     = req;
        bus.dmem_ready   = rdy;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.hazard_stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.dmem_req     = 1'b0;
        bus.dmem_ready   = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("rst_ctrl", 32'(ctrl()), 32'(C_OFF));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_stall", 32'(bus.stall_count), 32'd0);
        chk("rst_flush", 32'(bus.flush_count), 32'd0);
        chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_ctrl", 32'(ctrl()), 32'(C_IDLE));

        // load-use
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("loaduse_ctrl", 32'(ctrl()), 32'(C_LOAD));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("loaduse_cnt", 32'(bus.stall_count), 32'd1);

        // branch overrides load-use
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("branch_ctrl", 32'(ctrl()), 32'(C_FLUSH));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("branch_flush", 32'(bus.flush_count), 32'd1);
        chk("branch_stall", 32'(bus.stall_count), 32'd1);

        // memory wait N=3 with branch held
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("memw_c1", 32'(ctrl()), 32'(C_FREEZE));
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("memw_c2", 32'(ctrl()), 32'(C_FREEZE));
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("memw_c3", 32'(ctrl()), 32'(C_FLUSH));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("memw_stall", 32'(bus.stall_count), 32'd3);
        chk("memw_flush", 32'(bus.flush_count), 32'd2);

        // zero-wait access
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("zerowait_ctrl", 32'(ctrl()), 32'(C_IDLE));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("zerowait_stall", 32'(bus.stall_count), 32'd3);

        // watchdog expiry
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            chk("wd_freeze", 32'(ctrl()), 32'(C_FREEZE));
            chk("wd_no_timeout", 32'(bus.mem_timeout), 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wd_err_ctrl", 32'(ctrl()), 32'(C_OFF));
        chk("wd_err_flag", 32'(bus.mem_timeout), 32'd1);
        chk("wd_err_stall", 32'(bus.stall_count), 32'd7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wd_sticky_ctrl", 32'(ctrl()), 32'(C_OFF));
        chk("wd_sticky_flag", 32'(bus.mem_timeout), 32'd1);
        chk("wd_sticky_stall", 32'(bus.stall_count), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("wd_rst_ctrl", 32'(ctrl()), 32'(C_OFF));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("wd_rst_flag", 32'(bus.mem_timeout), 32'd0);
        chk("wd_rst_ctrl2", 32'(ctrl()), 32'(C_IDLE));
        chk("wd_rst_stall", 32'(bus.stall_count), 32'd0);

        // ready in the TIMEOUT-th cycle releases normally
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("wd_edge_ctrl", 32'(ctrl()), 32'(C_IDLE));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wd_edge_flag", 32'(bus.mem_timeout), 32'd0);
        chk("wd_edge_stall", 32'(bus.stall_count), 32'd3);
        chk("wd_edge_ctrl2", 32'(ctrl()), 32'(C_IDLE));

        // request dropped during wait acts as ready; hazard applies in release cycle
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("drop_ctrl", 32'(ctrl()), 32'(C_LOAD));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_stall", 32'(bus.stall_count), 32'd5);

        // counter wrap: 17 stall cycles from zero
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_stall", 32'(bus.stall_count), 32'd1);
        chk("wrap_flush", 32'(bus.flush_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
